// File: rtl/aes_sub_bytes_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sub_bytes_ctrl_n
//  Description : Responder-side controller for the active-low SubBytes
//                handshake of the hardened cipher control FSM. Sequences the
//                multi-cycle masked (DOM) S-box pipeline:
//                  - one-hot-in-time per-stage register enables,
//                  - output request LATENCY cycles after an accepted enable,
//                    held until acknowledged,
//                  - one-cycle PRD refresh pulse on handshake completion.
//                Protocol violations, counter/shift-register inconsistencies,
//                illegal state encodings and the external fatal alert all
//                drive the FSM into an absorbing ERROR state with a sticky
//                alert. Only rst_i leaves ERROR.
//
//  Parameters  : LATENCY     - S-box pipeline depth, accepted enable to
//                              output request (legal range 2..15)
//                STATE_WIDTH - sparse state encoding width (fixed at 6)
//
//  Ports       : clk_i          in   clock
//                rst_i          in   asynchronous reset, active-high
//                en_ni          in   SubBytes enable, active-low
//                out_req_no     out  output-valid request, active-low
//                out_ack_ni     in   output acknowledge, active-low
//                stage_en_o     out  [LATENCY] per-stage enables
//                busy_o         out  enable accepted, handshake not complete
//                prd_update_o   out  one-cycle fresh-randomness request
//                alert_fatal_i  in   external fatal alert
//                alert_o        out  sticky fatal alert
//
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_ctrl_n #(
    parameter int LATENCY     = 5,
    parameter int STATE_WIDTH = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_ni,
    output logic               out_req_no,
    input  logic               out_ack_ni,
    output logic [LATENCY-1:0] stage_en_o,
    output logic               busy_o,
    output logic               prd_update_o,
    input  logic               alert_fatal_i,
    output logic               alert_o
);

    // Stage 0 is decoded combinationally from the accepted enable; only
    // stages 1..LATENCY-1 need a register.
    localparam int         c_pipe_w   = LATENCY - 1;
    localparam logic [3:0] c_cnt_load = 4'(LATENCY - 2);

    // Sparse encoding, pairwise Hamming distance >= 3, so a single flipped
    // state bit can never turn one legal state into another.
    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 6'b001001,
        ST_BUSY  = 6'b010110,
        ST_DONE  = 6'b100011,
        ST_ERROR = 6'b111100
    } state_e;

    // ------------------------------------------------------------------------
    // Boundary inversion: everything below works on positive-sense signals.
    // ------------------------------------------------------------------------
    logic w_en;
    logic w_ack;

    assign w_en  = ~en_ni;
    assign w_ack = ~out_ack_ni;

    // ------------------------------------------------------------------------
    // State, counter and stage shift register
    // ------------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic [c_pipe_w-1:0] r_pipe;
    logic [c_pipe_w-1:0] w_pipe_shift;
    logic [c_pipe_w-1:0] w_pipe_next;
    logic [c_pipe_w-1:0] w_pipe_expect;

    logic w_accept;
    logic w_complete;
    logic w_idle_fault;
    logic w_busy_fault;
    logic w_done_fault;

    logic r_out_req_n;
    logic r_busy;
    logic r_alert;

    generate
        if (c_pipe_w == 1) begin : g_pipe_single
            assign w_pipe_shift = w_accept;
        end else begin : g_pipe_multi
            assign w_pipe_shift = {r_pipe[c_pipe_w-2:0], w_accept};
        end
    endgenerate

    // While BUSY the counter and the travelling enable bit describe the same
    // position: with counter value c the set bit must be at index
    // (LATENCY-2)-c. Any disagreement means a corrupted register.
    assign w_pipe_expect = c_pipe_w'(1) << (c_cnt_load - r_cnt);

    assign w_idle_fault = (r_cnt != 4'd0) || (r_pipe != '0);
    assign w_busy_fault = (r_cnt > c_cnt_load) || (r_pipe != w_pipe_expect);
    assign w_done_fault = (r_cnt != 4'd0) || (r_pipe != '0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ack || w_idle_fault) begin
                    w_state_next = ST_ERROR;
                end else if (w_en) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_en || w_ack || w_busy_fault) begin
                    w_state_next = ST_ERROR;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!w_en || w_done_fault) begin
                    w_state_next = ST_ERROR;
                end else if (w_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                w_state_next = ST_ERROR;
            end
            default: begin
                w_state_next = ST_ERROR;
            end
        endcase

        // The external alert overrides every other transition.
        if (alert_fatal_i) begin
            w_state_next = ST_ERROR;
            w_accept     = 1'b0;
            w_complete   = 1'b0;
        end

        // Nothing is accepted or completed while reset is held, so the
        // combinational outputs also sit at their reset values.
        if (rst_i) begin
            w_accept   = 1'b0;
            w_complete = 1'b0;
        end
    end

    always_comb begin
        w_cnt_next  = 4'd0;
        w_pipe_next = '0;
        if (w_state_next != ST_ERROR) begin
            w_pipe_next = w_pipe_shift;
            if (w_accept) begin
                w_cnt_next = c_cnt_load;
            end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
                w_cnt_next = r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_pipe      <= '0;
            r_out_req_n <= 1'b1;
            r_busy      <= 1'b0;
            r_alert     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pipe      <= w_pipe_next;
            r_out_req_n <= (w_state_next != ST_DONE);
            r_busy      <= (w_state_next == ST_BUSY) || (w_state_next == ST_DONE);
            // Sticky even if the state register itself gets disturbed later.
            r_alert     <= r_alert || (w_state_next == ST_ERROR);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stage_en_o   = {r_pipe, w_accept};
    assign out_req_no   = r_out_req_n;
    assign busy_o       = r_busy;
    assign prd_update_o = w_complete;
    assign alert_o      = r_alert;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_sub_bytes_ctrl_n
//  Description : Directed, scoreboard-checked bench for aes_sub_bytes_ctrl_n
//                (LATENCY = 5). Each stimulus cycle pushes the hand-derived
//                output vector for that cycle; a monitor pops and compares it
//                on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_sub_bytes_ctrl_n;

    localparam int c_lat = 5;

    logic             clk;
    logic             rst;
    logic             en_ni;
    logic             out_req_no;
    logic             out_ack_ni;
    logic [c_lat-1:0] stage_en_o;
    logic             busy_o;
    logic             prd_update_o;
    logic             alert_fatal_i;
    logic             alert_o;

    aes_sub_bytes_ctrl_n #(
        .LATENCY     (c_lat),
        .STATE_WIDTH (6)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_ni         (en_ni),
        .out_req_no    (out_req_no),
        .out_ack_ni    (out_ack_ni),
        .stage_en_o    (stage_en_o),
        .busy_o        (busy_o),
        .prd_update_o  (prd_update_o),
        .alert_fatal_i (alert_fatal_i),
        .alert_o       (alert_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_lat-1:0] stage;
        logic             req_n;
        logic             busy;
        logic             prd;
        logic             alert;
        string            nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // ------------------------------------------------------------------------
    // Monitor: one comparison per cycle that has an expectation queued.
    // ------------------------------------------------------------------------
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (stage_en_o !== e.stage || out_req_no !== e.req_n ||
                    busy_o !== e.busy || prd_update_o !== e.prd ||
                    alert_o !== e.alert) begin
                    failures++;
                    $display("FAIL %s: got stage=%b req_n=%b busy=%b prd=%b alert=%b, want stage=%b req_n=%b busy=%b prd=%b alert=%b",
                             e.nm, stage_en_o, out_req_no, busy_o, prd_update_o, alert_o,
                             e.stage, e.req_n, e.busy, e.prd, e.alert);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [c_lat-1:0] stage, input logic req_n,
                                input logic busy, input logic prd, input logic alert,
                                input string nm);
        exp_t e;
        e.stage = stage;
        e.req_n = req_n;
        e.busy  = busy;
        e.prd   = prd;
        e.alert = alert;
        e.nm    = nm;
        return e;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic step(input logic r, input logic en_n, input logic ack_n, input logic fat,
                        input logic [c_lat-1:0] stage, input logic req_n, input logic busy,
                        input logic prd, input logic alert, input string nm);
        @(posedge clk);
        #1;
        rst           = r;
        en_ni         = en_n;
        out_ack_ni    = ack_n;
        alert_fatal_i = fat;
        exp_q.push_back(mk(stage, req_n, busy, prd, alert, nm));
    endtask

    // Full request: acceptance cycle plus BUSY cycles 1..4, en_ni held low.
    task automatic run_busy(input string tag);
        step(0, 0, 1, 0, 5'b00001, 1, 0, 0, 0, {tag, " accept"});
        step(0, 0, 1, 0, 5'b00010, 1, 1, 0, 0, {tag, " stage1"});
        step(0, 0, 1, 0, 5'b00100, 1, 1, 0, 0, {tag, " stage2"});
        step(0, 0, 1, 0, 5'b01000, 1, 1, 0, 0, {tag, " stage3"});
        step(0, 0, 1, 0, 5'b10000, 1, 1, 0, 0, {tag, " stage4"});
    endtask

    task automatic do_reset(input string tag);
        step(1, 1, 1, 0, 5'b00000, 1, 0, 0, 0, {tag, " reset"});
        step(0, 1, 1, 0, 5'b00000, 1, 0, 0, 0, {tag, " idle"});
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : p_stim
        rst           = 1'b1;
        en_ni         = 1'b1;
        out_ack_ni    = 1'b1;
        alert_fatal_i = 1'b0;

        do_reset("init");

        // Basic request with an acknowledge delayed by three DONE cycles.
        run_busy("req1");
        step(0, 0, 1, 0, 5'b00000, 0, 1, 0, 0, "req1 done c5");
        step(0, 0, 1, 0, 5'b00000, 0, 1, 0, 0, "req1 done c6");
        step(0, 0, 1, 0, 5'b00000, 0, 1, 0, 0, "req1 done c7");
        step(0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, "req1 ack c8");

        // en_ni kept low: back-to-back requests, immediate acknowledge,
        // acceptance 6 cycles apart.
        run_busy("req2");
        step(0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, "req2 ack");
        run_busy("req3");
        step(0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, "req3 ack");
        step(0, 1, 1, 0, 5'b00000, 1, 0, 0, 0, "req3 idle");

        // Acknowledge during BUSY.
        step(0, 0, 1, 0, 5'b00001, 1, 0, 0, 0, "ackbusy accept");
        step(0, 0, 1, 0, 5'b00010, 1, 1, 0, 0, "ackbusy stage1");
        step(0, 0, 0, 0, 5'b00100, 1, 1, 0, 0, "ackbusy violation");
        step(0, 0, 1, 0, 5'b00000, 1, 0, 0, 1, "ackbusy alert");
        step(0, 0, 0, 0, 5'b00000, 1, 0, 0, 1, "ackbusy inputs ignored");
        step(0, 1, 1, 0, 5'b00000, 1, 0, 0, 1, "ackbusy alert sticky");
        do_reset("ackbusy");

        // Enable dropped in DONE.
        run_busy("endrop");
        step(0, 1, 1, 0, 5'b00000, 0, 1, 0, 0, "endrop in done");
        step(0, 1, 1, 0, 5'b00000, 1, 0, 0, 1, "endrop alert");
        step(0, 0, 0, 0, 5'b00000, 1, 0, 0, 1, "endrop alert sticky");
        do_reset("endrop");

        // External fatal alert pulsed in IDLE.
        step(0, 1, 1, 1, 5'b00000, 1, 0, 0, 0, "fatal pulse");
        step(0, 1, 1, 0, 5'b00000, 1, 0, 0, 1, "fatal alert");
        step(0, 0, 1, 0, 5'b00000, 1, 0, 0, 1, "fatal en ignored 1");
        step(0, 0, 1, 0, 5'b00000, 1, 0, 0, 1, "fatal en ignored 2");
        do_reset("fatal");

        // Asynchronous reset between clock edges in the middle of BUSY.
        step(0, 0, 1, 0, 5'b00001, 1, 0, 0, 0, "async accept");
        step(0, 0, 1, 0, 5'b00010, 1, 1, 0, 0, "async stage1");
        @(posedge clk);
        #1;
        en_ni = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.push_back(mk(5'b00000, 1, 0, 0, 0, "async reset mid busy"));
        step(1, 0, 1, 0, 5'b00000, 1, 0, 0, 0, "async reset held");
        run_busy("after reset");
        step(0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, "after reset ack");
        step(0, 1, 1, 0, 5'b00000, 1, 0, 0, 0, "after reset idle");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_sub_bytes_ctrl_n.md
Name: aes_sub_bytes_ctrl_n

Overview:
- Responder side of the inverted-polarity SubBytes handshake driven by the hardened cipher control FSM (enable / out-request / out-acknowledge, all active-low on the wire).
- Sequences the multi-cycle masked (DOM) S-box pipeline:
  - generates per-stage enables;
  - raises the output request after a fixed latency;
  - holds it until acknowledged;
  - pulses a PRD refresh on completion.
- Detects protocol violations and state-register faults, and escalates them to a sticky fatal alert.

Parameters:
- Latency, 5, S-box pipeline depth in cycles from accepted enable to output request; legal range 2..15.
- StateWidth, 6, width of the sparse FSM state encoding (fixed; not user-tunable).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- en_ni  input  1  SubBytes enable from control FSM, active-low
- out_req_no  output  1  output-valid request to control FSM, active-low
- out_ack_ni  input  1  acknowledge from control FSM, active-low
- stage_en_o  output  Latency  per-stage register enables of the S-box pipeline, one-hot-in-time
- busy_o  output  1  high from enable acceptance until handshake completion
- prd_update_o  output  1  one-cycle pulse requesting fresh masking randomness
- alert_fatal_i  input  1  external fatal alert; forces ERROR
- alert_o  output  1  sticky fatal alert

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE;
  - out_req_no = 1;
  - stage_en_o = 0;
  - busy_o = 0;
  - prd_update_o = 0;
  - alert_o = 0;
  - counter = 0.
- Reset asserted mid-operation returns to IDLE immediately, with all outputs at their reset values.
- State encoding: sparse 6-bit, minimum Hamming distance 3:
  - IDLE = 6'b001001
  - BUSY = 6'b010110
  - DONE = 6'b100011
  - ERROR = 6'b111100
  - Any other value decodes to ERROR on the next edge.
- Active-low inputs are inverted once at the boundary. All logic below uses the positive-sense en / ack / req.
- IDLE:
  - en seen in cycle t -> stage_en_o[0] = 1 in cycle t (combinational from en) -> next state BUSY, counter = Latency-2.
  - ack in IDLE -> ERROR.
- BUSY:
  - busy_o = 1.
  - stage_en_o[k] = 1 in cycle t+k, via a Latency-bit shift register fed by the accepted enable; at most one bit is high at a time.
  - counter decrements each cycle; at counter == 0 the next state is DONE.
  - en dropped (en_ni = 1) while BUSY -> ERROR.
  - ack while BUSY -> ERROR.
- DONE:
  - Entered at cycle t+Latency.
  - out_req_no = 0 and busy_o = 1; held until ack.
  - ack and en both seen in the same cycle -> handshake completes:
    - prd_update_o = 1 for that cycle only;
    - next state IDLE;
    - out_req_no returns to 1 next cycle.
  - en dropped without ack -> ERROR.
- Back-to-back: en still asserted in the IDLE cycle after completion is a new request and is accepted in that cycle, so the minimum request spacing is Latency+1 cycles.
- ERROR:
  - absorbing; only rst_i exits;
  - alert_o = 1;
  - out_req_no = 1, stage_en_o = 0, busy_o = 0, prd_update_o = 0.
  - en and ack are ignored.
- alert_fatal_i = 1 in any state -> ERROR on the next edge. This takes priority over all other transitions.
- Counter: 4 bits, no wrap. Reaching 0 forces the BUSY->DONE transition. Any counter value above Latency-2 while in BUSY -> ERROR (fault check).
- Outputs are registered except stage_en_o[0] and prd_update_o, which are decoded from the current state and the boundary-inverted inputs.

Test Plan:
- Reset, then en_ni = 0 at cycle 0 (Latency = 5) -> stage_en_o = 00001, 00010, 00100, 01000, 10000 on cycles 0..4; out_req_no = 0 from cycle 5; busy_o = 1 on cycles 1..5.
- Hold out_ack_ni = 1 for 3 cycles in DONE, then 0 at cycle 8 -> out_req_no stays 0 through cycle 8; prd_update_o = 1 only at cycle 8; out_req_no = 1 at cycle 9.
- en_ni held 0 continuously -> second acceptance in the cycle after the ack; out_req_no = 0 again 5 cycles later; spacing is exactly 6 cycles.
- out_ack_ni = 0 at cycle 2 of BUSY, or en_ni = 1 in DONE -> alert_o = 1 next cycle, all other outputs idle, and it persists; rst_i pulse -> alert_o = 0 and state IDLE.
- alert_fatal_i pulsed for 1 cycle in IDLE -> alert_o = 1 thereafter; en_ni = 0 is then ignored (stage_en_o stays 0).
- rst_i asserted asynchronously mid-BUSY (between clock edges) -> out_req_no = 1, stage_en_o = 0, busy_o = 0 immediately; after release, a new enable completes with normal 5-cycle latency.
